// File: rtl/instr_memory.sv
// Loadable instruction store: a program is streamed in during LOAD, then read
// back with one-cycle latency in RUN. Invalid reads return HALT_CMD with zero data.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_RUN  | program readable below size; load inputs other than start ignored
// ST_LOAD | words accepted at the write pointer; every read returns HALT_CMD
module instr_memory #(
  parameter int                   CMD_WIDTH  = 4,
  parameter int                   DATA_WIDTH = 28,
  parameter int                   ADDR_WIDTH = 4,
  parameter int                   DEPTH      = 15,
  parameter logic [CMD_WIDTH-1:0] HALT_CMD   = 4'b1010
) (
  input  logic                         clockInstrMemory,
  input  logic                         resetInstrMemory,
  input  logic [ADDR_WIDTH-1:0]        addressInstrMemory,
  input  logic                         readInstrMemory,
  output logic [CMD_WIDTH-1:0]         comandInstrMemory,
  output logic signed [DATA_WIDTH-1:0] dataInstrMemory,
  output logic                         validInstrMemory,
  input  logic                         loadStartInstrMemory,
  input  logic                         loadDoneInstrMemory,
  input  logic                         loadValidInstrMemory,
  input  logic [CMD_WIDTH-1:0]         loadComandInstrMemory,
  input  logic signed [DATA_WIDTH-1:0] loadDataInstrMemory,
  output logic                         loadReadyInstrMemory,
  output logic [ADDR_WIDTH:0]          sizeInstrMemory,
  output logic                         overflowInstrMemory,
  output logic                         loadingInstrMemory
);

  typedef enum logic {ST_RUN = 1'b0, ST_LOAD = 1'b1} state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_L = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] ONE_L   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                       r_state;
  state_t                       w_state_next;
  // The write pointer and the loaded size always move together, so one register serves both.
  logic [ADDR_WIDTH:0]          r_size;
  logic                         r_overflow;
  logic [CMD_WIDTH-1:0]         r_mem_cmd  [DEPTH];
  logic signed [DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic [CMD_WIDTH-1:0]         r_rd_cmd;
  logic signed [DATA_WIDTH-1:0] r_rd_data;
  logic                         r_rd_valid;

  logic w_load_ready;
  logic w_accept;
  logic w_read_hit;

  assign w_load_ready = (r_state == ST_LOAD) && (r_size < DEPTH_L);
  assign w_accept     = w_load_ready && loadValidInstrMemory && !loadStartInstrMemory;
  assign w_read_hit   = (r_state == ST_RUN) && ({1'b0, addressInstrMemory} < r_size);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:  if (loadStartInstrMemory) w_state_next = ST_LOAD;
      ST_LOAD: if (!loadStartInstrMemory && loadDoneInstrMemory) w_state_next = ST_RUN;
      default: w_state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clockInstrMemory) begin
    if (resetInstrMemory) r_state <= ST_RUN;
    else                  r_state <= w_state_next;
  end

  // Restart outranks any word offered in the same cycle, in either state.
  always_ff @(posedge clockInstrMemory) begin
    if (resetInstrMemory || loadStartInstrMemory) begin
      r_size     <= '0;
      r_overflow <= 1'b0;
    end else if (r_state == ST_LOAD && loadValidInstrMemory) begin
      if (w_load_ready) r_size     <= r_size + ONE_L;
      else              r_overflow <= 1'b1;
    end
  end

  // Storage is deliberately unreset; visibility is gated by size instead.
  always_ff @(posedge clockInstrMemory) begin
    if (w_accept) begin
      r_mem_cmd[r_size[ADDR_WIDTH-1:0]]  <= loadComandInstrMemory;
      r_mem_data[r_size[ADDR_WIDTH-1:0]] <= loadDataInstrMemory;
    end
  end

  always_ff @(posedge clockInstrMemory) begin
    if (resetInstrMemory) begin
      r_rd_cmd   <= HALT_CMD;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= readInstrMemory;
      if (readInstrMemory) begin
        if (w_read_hit) begin
          r_rd_cmd  <= r_mem_cmd[addressInstrMemory];
          r_rd_data <= r_mem_data[addressInstrMemory];
        end else begin
          r_rd_cmd  <= HALT_CMD;
          r_rd_data <= '0;
        end
      end
    end
  end

  assign comandInstrMemory    = r_rd_cmd;
  assign dataInstrMemory      = r_rd_data;
  assign validInstrMemory     = r_rd_valid;
  assign loadReadyInstrMemory = w_load_ready;
  assign sizeInstrMemory      = r_size;
  assign overflowInstrMemory  = r_overflow;
  assign loadingInstrMemory   = (r_state == ST_LOAD);

endmodule

// File: tb/tb_instr_memory.sv
// Bench for instr_memory: directed scenarios plus a randomized run, all checked
// against a program-level model of the store (loading flag, size, contents).
module tb_instr_memory;
  localparam int CW = 4;
  localparam int DW = 28;
  localparam int AW = 4;
  localparam int DEPTH = 15;
  localparam logic [CW-1:0] HALT = 4'b1010;

  logic clk = 1'b0;
  logic rst, rd, ls, ld, lv;
  logic [AW-1:0] addr;
  logic [CW-1:0] lcmd;
  logic signed [DW-1:0] ldata;
  logic [CW-1:0] o_cmd;
  logic signed [DW-1:0] o_data;
  logic o_valid, o_ready, o_ovf, o_loading;
  logic [AW:0] o_size;

  int n_checks = 0;
  int n_errors = 0;

  // Model of the store at the level of the program being loaded.
  logic [CW-1:0]        m_cmd  [DEPTH];
  logic signed [DW-1:0] m_data [DEPTH];
  int                   m_size = 0;
  bit                   m_loading = 0;
  bit                   m_ovf = 0;
  logic [CW-1:0]        e_cmd = HALT;
  logic signed [DW-1:0] e_data = '0;
  bit                   e_valid = 0;

  always #5 clk = ~clk;

  instr_memory dut (
    .clockInstrMemory(clk), .resetInstrMemory(rst),
    .addressInstrMemory(addr), .readInstrMemory(rd),
    .comandInstrMemory(o_cmd), .dataInstrMemory(o_data), .validInstrMemory(o_valid),
    .loadStartInstrMemory(ls), .loadDoneInstrMemory(ld),
    .loadValidInstrMemory(lv), .loadComandInstrMemory(lcmd), .loadDataInstrMemory(ldata),
    .loadReadyInstrMemory(o_ready), .sizeInstrMemory(o_size),
    .overflowInstrMemory(o_ovf), .loadingInstrMemory(o_loading)
  );

  task automatic idle();
    rst = 0; rd = 0; ls = 0; ld = 0; lv = 0; addr = '0; lcmd = '0; ldata = '0;
  endtask

  // Advance one clock: update the model from the inputs now applied, then sample at edge+1.
  task automatic cycle();
    if (rst) begin
      m_loading = 0; m_size = 0; m_ovf = 0;
      e_cmd = HALT; e_data = '0; e_valid = 0;
    end else begin
      e_valid = rd;
      if (rd) begin
        if (!m_loading && int'(addr) < m_size) begin
          e_cmd = m_cmd[addr]; e_data = m_data[addr];
        end else begin
          e_cmd = HALT; e_data = '0;
        end
      end
      if (ls) begin
        m_loading = 1; m_size = 0; m_ovf = 0;
      end else if (m_loading) begin
        if (lv) begin
          if (m_size < DEPTH) begin
            m_cmd[m_size] = lcmd; m_data[m_size] = ldata; m_size++;
          end else m_ovf = 1;
        end
        if (ld) m_loading = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [CW-1:0] c, input logic signed [DW-1:0] d);
    idle(); lv = 1; lcmd = c; ldata = d; cycle();
  endtask

  task automatic start_load();
    idle(); ls = 1; cycle();
  endtask

  task automatic done_load();
    idle(); ld = 1; cycle();
  endtask

  task automatic read_at(input logic [AW-1:0] a);
    idle(); rd = 1; addr = a; cycle();
  endtask

  task automatic test_reset();
    idle(); rst = 1; cycle(); cycle(); idle();
    n_checks++; if (o_cmd !== HALT) begin n_errors++; $display("FAIL reset_cmd: got %b expected %b", o_cmd, HALT); end
    n_checks++; if (o_data !== 0) begin n_errors++; $display("FAIL reset_data: got %0d expected 0", o_data); end
    n_checks++; if (o_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    n_checks++; if (o_size !== 0) begin n_errors++; $display("FAIL reset_size: got %0d expected 0", o_size); end
    n_checks++; if (o_ovf !== 1'b0) begin n_errors++; $display("FAIL reset_ovf: got %b expected 0", o_ovf); end
    n_checks++; if (o_loading !== 1'b0) begin n_errors++; $display("FAIL reset_loading: got %b expected 0", o_loading); end
    n_checks++; if (o_ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %b expected 0", o_ready); end
  endtask

  task automatic test_load();
    start_load();
    n_checks++; if (o_loading !== 1'b1 || o_ready !== 1'b1) begin n_errors++; $display("FAIL load_enter: loading %b ready %b expected 1 1", o_loading, o_ready); end
    push_word(4'b0001, 350);
    push_word(4'b0011, -915);
    push_word(4'b0011, 2);
    push_word(4'b0110, 0);
    push_word(4'b1001, 0);
    done_load();
    n_checks++; if (o_loading !== 1'b0) begin n_errors++; $display("FAIL load_exit: loading %b expected 0", o_loading); end
    read_at(4'd1);
    n_checks++; if (o_cmd !== 4'b0011 || o_data !== -915 || o_valid !== 1'b1)
      begin n_errors++; $display("FAIL load_read1: got %b/%0d/%b expected 0011/-915/1", o_cmd, o_data, o_valid); end
    n_checks++; if (o_size !== 5) begin n_errors++; $display("FAIL load_size: got %0d expected 5", o_size); end
    read_at(4'd5);
    n_checks++; if (o_cmd !== HALT || o_data !== 0 || o_valid !== 1'b1)
      begin n_errors++; $display("FAIL oor_read5: got %b/%0d/%b expected 1010/0/1", o_cmd, o_data, o_valid); end
    read_at(4'd4);
    n_checks++; if (o_cmd !== 4'b1001 || o_data !== 0) begin n_errors++; $display("FAIL read4: got %b/%0d expected 1001/0", o_cmd, o_data); end
    read_at(4'd0);
    idle(); cycle();
    n_checks++; if (o_valid !== 1'b0 || o_cmd !== 4'b0001 || o_data !== 350)
      begin n_errors++; $display("FAIL read_hold: got %b/%0d/%b expected 0001/350/0", o_cmd, o_data, o_valid); end
  endtask

  task automatic test_overflow();
    bit ready_ok = 1;
    start_load();
    for (int i = 0; i < 16; i++) begin
      if (o_ready !== (i < DEPTH)) ready_ok = 0;
      push_word(CW'(i), DW'(i * 1000 - 7000));
    end
    n_checks++; if (!ready_ok) begin n_errors++; $display("FAIL ovf_ready_seq: ready did not drop exactly after word 15"); end
    n_checks++; if (o_ovf !== 1'b1 || o_size !== 15) begin n_errors++; $display("FAIL ovf_state: ovf %b size %0d expected 1 15", o_ovf, o_size); end
    n_checks++; if (o_ready !== 1'b0) begin n_errors++; $display("FAIL ovf_ready: got %b expected 0", o_ready); end
    done_load();
    read_at(4'd14);
    n_checks++; if (o_cmd !== 4'd14 || o_data !== 7000) begin n_errors++; $display("FAIL ovf_last_word: got %b/%0d expected 1110/7000", o_cmd, o_data); end
    start_load();
    n_checks++; if (o_ovf !== 1'b0 || o_size !== 0) begin n_errors++; $display("FAIL ovf_clear: ovf %b size %0d expected 0 0", o_ovf, o_size); end
    done_load();
  endtask

  task automatic test_reset_mid_load();
    start_load();
    push_word(4'b0101, 11); push_word(4'b0110, -12); push_word(4'b0111, 13);
    idle(); rst = 1; cycle(); idle();
    n_checks++; if (o_loading !== 1'b0 || o_size !== 0) begin n_errors++; $display("FAIL rml_state: loading %b size %0d expected 0 0", o_loading, o_size); end
    read_at(4'd0);
    n_checks++; if (o_cmd !== HALT || o_data !== 0 || o_valid !== 1'b1)
      begin n_errors++; $display("FAIL rml_read: got %b/%0d/%b expected 1010/0/1", o_cmd, o_data, o_valid); end
  endtask

  task automatic test_read_during_load();
    start_load();
    push_word(4'b1100, -1); push_word(4'b0010, 77);
    read_at(4'd0);
    n_checks++; if (o_cmd !== HALT || o_data !== 0 || o_valid !== 1'b1)
      begin n_errors++; $display("FAIL rdl_read: got %b/%0d/%b expected 1010/0/1", o_cmd, o_data, o_valid); end
    idle(); ld = 1; rd = 1; addr = 4'd0; cycle();
    n_checks++; if (o_cmd !== HALT || o_valid !== 1'b1) begin n_errors++; $display("FAIL rdl_exit_read: got %b/%b expected 1010/1", o_cmd, o_valid); end
    read_at(4'd0);
    n_checks++; if (o_cmd !== 4'b1100 || o_data !== -1 || o_valid !== 1'b1)
      begin n_errors++; $display("FAIL rdl_after: got %b/%0d/%b expected 1100/-1/1", o_cmd, o_data, o_valid); end
  endtask

  task automatic test_simultaneous();
    start_load();
    push_word(4'b0100, 400);
    idle(); ls = 1; ld = 1; lv = 1; lcmd = 4'b1111; ldata = -5; cycle();
    n_checks++; if (o_size !== 0 || o_loading !== 1'b1) begin n_errors++; $display("FAIL simul_state: size %0d loading %b expected 0 1", o_size, o_loading); end
    push_word(4'b0001, 9);
    n_checks++; if (o_size !== 1) begin n_errors++; $display("FAIL simul_next: size %0d expected 1", o_size); end
    done_load();
    read_at(4'd0);
    n_checks++; if (o_cmd !== 4'b0001 || o_data !== 9) begin n_errors++; $display("FAIL simul_read: got %b/%0d expected 0001/9", o_cmd, o_data); end
  endtask

  task automatic test_random();
    int errs_before = n_errors;
    for (int i = 0; i < 600; i++) begin
      idle();
      rst   = ($urandom_range(0, 59) == 0);
      rd    = $urandom_range(0, 1);
      addr  = AW'($urandom_range(0, 15));
      ls    = ($urandom_range(0, 11) == 0);
      ld    = ($urandom_range(0, 9) == 0);
      lv    = $urandom_range(0, 1);
      lcmd  = CW'($urandom);
      ldata = DW'($urandom);
      n_checks++; if (o_ready !== (m_loading && m_size < DEPTH))
        begin n_errors++; $display("FAIL rnd_ready[%0d]: got %b expected %b", i, o_ready, m_loading && m_size < DEPTH); end
      cycle();
      n_checks++; if (o_valid !== e_valid) begin n_errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, o_valid, e_valid); end
      n_checks++; if (o_cmd !== e_cmd || o_data !== e_data)
        begin n_errors++; $display("FAIL rnd_read[%0d]: got %b/%0d expected %b/%0d", i, o_cmd, o_data, e_cmd, e_data); end
      n_checks++; if (int'(o_size) != m_size || o_ovf !== m_ovf || o_loading !== m_loading)
        begin n_errors++; $display("FAIL rnd_status[%0d]: size %0d ovf %b loading %b expected %0d %b %b", i, o_size, o_ovf, o_loading, m_size, m_ovf, m_loading); end
      if (n_errors - errs_before > 10) break;
    end
  endtask

  initial begin
    idle();
    rst = 1;
    test_reset();
    test_load();
    test_overflow();
    test_reset_mid_load();
    test_read_during_load();
    test_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
